// File: rtl/operand_fetch_pkg.sv
// Shared constants and forwarding-source encoding for the operand fetch stage.
package operand_fetch_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_DM = 2'd2,
        FWD_WB = 2'd3
    } fwd_sel_e;

    // Youngest producer wins; a zero source address never forwards.
    function automatic fwd_sel_e fwd_pick(input logic src_nz, input logic ex_hit,
                                          input logic dm_hit, input logic wb_hit);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (src_nz) begin
            if (ex_hit) begin
                sel = FWD_EX;
            end else if (dm_hit) begin
                sel = FWD_DM;
            end else if (wb_hit) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 hardwired to 0.
// Define OPERAND_FETCH_RF_RESET_EN to clear every entry on rst_n.
module operand_fetch_regfile
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra0,
    output logic [DATA_W-1:0] rd0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NREGS];
    logic              wr_en;

    assign wr_en = we && (wa != '0);

    assign rd0 = (ra0 == '0) ? '0 : mem_q[ra0];
    assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];

`ifdef OPERAND_FETCH_RF_RESET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wa] <= wd;
        end
    end
`else
    // Storage carries no reset in this build.
    logic unused_rst_n;
    assign unused_rst_n = rst_n;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wa] <= wd;
        end
    end
`endif

endmodule

// File: rtl/operand_fetch.sv
// ID stage operand fetch: register read, EX/DM/WB forwarding, load-use stall, ID/EX registers.
// Build option OPERAND_FETCH_RF_RESET_EN resets the register file contents.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [DATA_W-1:0] imm,
    input  logic              imm_sel,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_rw,
    input  logic [DATA_W-1:0] ex_ans,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_rw,
    input  logic [DATA_W-1:0] dm_ans,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rw,
    input  logic [DATA_W-1:0] wb_ans,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic [DATA_W-1:0] a_q,
    output logic [DATA_W-1:0] b_q,
    output logic              out_valid
);

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic              ex_fwd_ok;
    fwd_sel_e          sel_a;
    fwd_sel_e          sel_b;

    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_d;
    logic              out_valid_d;
    logic              out_valid_q;

    operand_fetch_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_we),
        .wa    (wb_rw),
        .wd    (wb_ans),
        .ra0   (ra),
        .rd0   (rf_a),
        .ra1   (rb),
        .rd1   (rf_b)
    );

    // A load in EX has no data yet, so it never forwards; the stall covers that case.
    assign ex_fwd_ok = ex_we && !ex_is_load;

    assign sel_a = fwd_pick(ra != '0, ex_fwd_ok && (ex_rw == ra),
                            dm_we && (dm_rw == ra), wb_we && (wb_rw == ra));
    assign sel_b = fwd_pick(rb != '0, ex_fwd_ok && (ex_rw == rb),
                            dm_we && (dm_rw == rb), wb_we && (wb_rw == rb));

    always_comb begin
        fwd_a = rf_a;
        case (sel_a)
            FWD_EX:  fwd_a = ex_ans;
            FWD_DM:  fwd_a = dm_ans;
            FWD_WB:  fwd_a = wb_ans;
            default: fwd_a = rf_a;
        endcase
    end

    always_comb begin
        fwd_b = rf_b;
        case (sel_b)
            FWD_EX:  fwd_b = ex_ans;
            FWD_DM:  fwd_b = dm_ans;
            FWD_WB:  fwd_b = wb_ans;
            default: fwd_b = rf_b;
        endcase
    end

    assign op_b = imm_sel ? imm : fwd_b;

    assign stall = in_valid && ex_we && ex_is_load && (ex_rw != '0) &&
                   ((ex_rw == ra) || ((ex_rw == rb) && !imm_sel));

    // Flush beats hold beats stall; only a clean load moves the data registers.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (hold) begin
            out_valid_d = out_valid_q;
        end else if (stall) begin
            out_valid_d = 1'b0;
        end else begin
            a_d         = fwd_a;
            b_d         = op_b;
            out_valid_d = in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

endmodule
